// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter over four requesters feeding a single 8-bit UART transmitter
// with optional even/odd parity.
module uart_tx_scheduler #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [3:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    output logic [3:0] gnt,
    output logic       tx,
    output logic       busy,
    output logic [3:0] done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_d;
    logic [1:0] rr_ptr, rr_ptr_d, owner, owner_d, win;
    logic [2:0] cnt, cnt_d;
    logic [7:0] shreg, shreg_d, sel_data;
    logic       found, tx_d;

    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[rr_ptr + 2'(i)]) begin
                win   = rr_ptr + 2'(i);
                found = 1'b1;
            end
        end
        sel_data = win == 2'd0 ? data0 : win == 2'd1 ? data1 : win == 2'd2 ? data2 : data3;
    end

    // gnt and done are combinational; gnt is gated by reset so it cannot pulse while reset is held
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        shreg_d  = shreg;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        gnt      = '0;
        done     = '0;
        case (state)
            IDLE: if (found && reset) begin
                gnt[win] = 1'b1;
                shreg_d  = sel_data;
                owner_d  = win;
                state_d  = START;
            end
            START: if (baud_tick) begin
                state_d = DATA;
                cnt_d   = 3'd0;
            end
            DATA: if (baud_tick) begin
                if (cnt == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
                else cnt_d = cnt + 3'd1;
            end
            PARITY: if (baud_tick) state_d = STOP;
            STOP: if (baud_tick) begin
                state_d     = IDLE;
                done[owner] = 1'b1;
                rr_ptr_d    = owner + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        tx_d = state_d == START  ? 1'b0 :
               state_d == DATA   ? shreg_d[cnt_d] :
               state_d == PARITY ? (^shreg_d) ^ PARITY_ODD : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            tx     <= 1'b1;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            shreg  <= shreg_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
            tx     <= tx_d;
        end
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: two configurations (even parity, and no parity with odd-parity setting)
// driven with shared random stimulus and checked against a frame-level reference model.
module tb_uart_tx_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud_tick = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] data [4];
    logic [3:0] gnt [2];
    logic [3:0] done [2];
    logic       tx [2];
    logic       busy [2];

    int n_cmp = 0;
    int n_err = 0;

    bit          m_busy [2];
    int          m_pos [2];
    int          m_rr [2];
    int          m_own [2];
    logic [10:0] m_bits [2];
    logic [3:0]  eg, ed;
    int          j;
    bit          tick_auto = 1'b1;
    int          gap = 2;
    bit          rec = 1'b0;
    logic [3:0]  seen [$];
    logic [3:0]  rr_exp [5];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .req(req),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .gnt(gnt[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0])
    );

    uart_tx_scheduler #(.PARITY_EN(1'b0), .PARITY_ODD(1'b1)) u_nopar (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .req(req),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .gnt(gnt[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int k);
        return k == 0 ? 11 : 10;
    endfunction

    // Frame = start 0, eight data bits LSB first, optional parity, stop 1
    function automatic logic [10:0] frame_bits(input int k, input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        if (k == 0) b[9] = ^d;
        return b;
    endfunction

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            eg = '0;
            ed = '0;
            if (!reset) begin
                m_busy[k] = 1'b0;
                m_rr[k]   = 0;
                check($sformatf("rst_tx%0d", k), tx[k], 1);
                check($sformatf("rst_busy%0d", k), busy[k], 0);
            end else if (!m_busy[k]) begin
                check($sformatf("idle_tx%0d", k), tx[k], 1);
                check($sformatf("idle_busy%0d", k), busy[k], 0);
                for (int i = 0; i < 4; i++) begin
                    j = (m_rr[k] + i) % 4;
                    if (eg == 0 && req[j]) begin
                        eg        = 4'(1 << j);
                        m_own[k]  = j;
                        m_busy[k] = 1'b1;
                        m_pos[k]  = 0;
                        m_bits[k] = frame_bits(k, data[j]);
                    end
                end
            end else begin
                check($sformatf("tx%0d_pos%0d", k, m_pos[k]), tx[k], m_bits[k][m_pos[k]]);
                check($sformatf("busy%0d", k), busy[k], 1);
                if (baud_tick) begin
                    if (m_pos[k] == frame_len(k) - 1) begin
                        ed        = 4'(1 << m_own[k]);
                        m_busy[k] = 1'b0;
                        m_rr[k]   = (m_own[k] + 1) % 4;
                    end else m_pos[k]++;
                end
            end
            check($sformatf("gnt%0d", k), gnt[k], eg);
            check($sformatf("done%0d", k), done[k], ed);
            if (k == 0 && rec && gnt[0] != 0) seen.push_back(gnt[0]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tick_auto) begin
                baud_tick = gap == 0;
                gap = baud_tick ? int'($urandom_range(3, 1)) : gap - 1;
            end
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((m_busy[0] || m_busy[1]) && b < 400) begin
            step(1);
            b++;
        end
        check("idle_timeout", {busy[0], busy[1]}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic send(input logic [3:0] r);
        req = r;
        step(1);
        req = '0;
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'hf;
        step(3);
        rec = 1'b1;
        reset = 1'b1;
        for (int b = 0; b < 1000 && seen.size() < 5; b++) step(1);
        rec = 1'b0;
        req = '0;
        check("rr_count", seen.size() >= 5, 1);
        for (int i = 0; i < 5 && i < seen.size(); i++) check($sformatf("rr_order%0d", i), seen[i], rr_exp[i]);
        wait_idle();

        do_reset();
        data[0] = 8'hA5;
        send(4'b0001);

        do_reset();
        send(4'b0010);
        req = 4'b0011;
        #1;
        check("wrap_gnt", gnt[0], 4'b0001);
        step(1);
        req = '0;
        wait_idle();
        send(4'b0010);

        for (int i = 0; i < 4; i++) data[i] = 8'hFF;
        send(4'b0001);
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        send(4'b0001);

        tick_auto = 1'b0;
        req = 4'b0100;
        data[2] = 8'h3C;
        baud_tick = 1'b1;
        step(1);
        baud_tick = 1'b0;
        tick_auto = 1'b1;
        gap = 3;
        step(8);
        req = '0;
        data[2] = 8'hC3;
        wait_idle();

        do_reset();
        data[0] = 8'($urandom);
        req = 4'b0001;
        step(1);
        req = '0;
        for (int b = 0; b < 400 && m_pos[0] != 5; b++) step(1);
        check("reach_bit4", m_pos[0], 5);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("abort_tx%0d", k), tx[k], 1);
            check($sformatf("abort_busy%0d", k), busy[k], 0);
            check($sformatf("abort_done%0d", k), done[k], 0);
        end
        step(2);
        reset = 1'b1;
        req = 4'b0100;
        #1;
        check("post_rst_gnt", gnt[0], 4'b0100);
        step(1);
        req = '0;
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7, 0) == 0) req = 4'($urandom);
            for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
            step(1);
        end
        req = '0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter PARITY_EN, default 1, meaning 1 = parity bit inserted, 0 = no parity bit.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port baud_tick  input  1  single-cycle pulse, one per bit period.
REQ-006 The block SHALL have port req  input  4  per-requester transmit request, level-sensitive.
REQ-007 The block SHALL have port data0..data3  input  8 each  per-requester payload byte.
REQ-008 The block SHALL have port gnt  output  4  one-hot grant, single-cycle pulse when a byte is accepted.
REQ-009 The block SHALL have port tx  output  1  serial line, idle high.
REQ-010 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 The block SHALL have port done  output  4  one-hot, single-cycle pulse to the served requester at frame end.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE with req != 0, the block SHALL select the first set req bit at or after rr_ptr, searching upward and wrapping 3->0.
REQ-014 In the selection cycle, the block SHALL pulse gnt for the winner, latch its data byte into an internal shift register and a 2-bit owner index, and enter START on the next edge.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-016 tx SHALL be registered: 1 in IDLE and STOP, 0 in START, the current data bit in DATA, and the parity bit in PARITY.
REQ-017 Each of START, DATA-per-bit, PARITY and STOP SHALL last until the next baud_tick; the transition occurs on the edge where baud_tick = 1.
REQ-018 DATA SHALL send bit 0 first (LSB-first); a 3-bit counter SHALL count 0..7, and the tick at count 7 SHALL leave DATA.
REQ-019 On leaving DATA, the FSM SHALL go to PARITY if PARITY_EN = 1, else to STOP.
REQ-020 The parity bit SHALL equal XOR of the latched byte, inverted when PARITY_ODD = 1.
REQ-021 On the baud_tick in STOP, the block SHALL return to IDLE, pulse done[owner] for one cycle, and set rr_ptr = owner + 1 modulo 4.
REQ-022 The earliest next grant SHALL be the cycle after return to IDLE; back-to-back frames SHALL therefore have at least one stop-bit period of tx = 1.
REQ-023 req changes and data changes after grant SHALL NOT affect the frame in flight.
REQ-024 A baud_tick arriving in the same cycle as a grant SHALL be ignored; START then lasts a full tick period.
REQ-025 gnt and done SHALL never have more than one bit set, and gnt SHALL never pulse while busy = 1.
REQ-026 Frame length SHALL be 11 baud_ticks after START entry with PARITY_EN = 1, and 10 with PARITY_EN = 0.

Reset
REQ-027 While reset = 0, the block SHALL force state IDLE, tx = 1, busy = 0, gnt = 0, done = 0, rr_ptr = 0, bit counter = 0 and shift register = 0, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (tx = 1) with no done pulse; after release, arbitration SHALL restart from rr_ptr = 0.

Verification
REQ-029 Scenario: req=0001, data0=0xA5, PARITY_EN=1 even -> gnt=0001; tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1; done=0001 after the 11th tick.
REQ-030 Scenario: req=1111 held continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001, each issued one cycle after the previous done.
REQ-031 Scenario: rr_ptr=2 (after serving requester 1), req=0011 -> gnt=0001 (wrap-around); then req=0010 -> gnt=0010.
REQ-032 Scenario: PARITY_EN=0, data=0xFF -> 10-tick frame 0,1x8,1; PARITY_ODD=1, data=0x00 -> parity bit = 1.
REQ-033 Scenario: reset pulled low during DATA bit 4 -> tx=1 and busy=0 in the same cycle, no done pulse; after release, req=0100 -> gnt=0100.
REQ-034 Scenario: baud_tick coincident with grant, and req dropped mid-frame -> START still lasts one full tick period and the frame completes unchanged.
